// File: rtl/xgcd_store_pkg.sv
// Shared types and sizing/decode helpers for the XGCD operand store.
package xgcd_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_DEPTH     = 32;
    localparam int unsigned DEF_NUM_BANKS = 2;
    localparam int unsigned DEF_ADDR_W    = 32;

    function automatic int unsigned calc_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned calc_bank_w(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int unsigned calc_bank_lsb(input int unsigned data_w, input int unsigned depth);
        return $clog2(data_w / 8) + $clog2(depth);
    endfunction

    // Everything from the bank field upward must name an existing bank.
    function automatic logic addr_hit(input logic [63:0] addr, input int unsigned bank_lsb,
                                      input int unsigned num_banks);
        return (addr >> bank_lsb) < 64'(num_banks);
    endfunction

    function automatic logic bank_hit(input int unsigned bank, input int unsigned num_banks);
        return bank < num_banks;
    endfunction

endpackage

// File: rtl/xgcd_store_arb.sv
// Two-requester round-robin arbiter; pointer moves only on contended, unfrozen cycles.
module xgcd_store_arb (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a_c,
    output logic gnt_b_c
);

    logic prio_b_q, prio_b_d;

    always_comb begin
        gnt_a_c  = 1'b0;
        gnt_b_c  = 1'b0;
        prio_b_d = prio_b_q;
        if (!freeze) begin
            if (req_a && req_b) begin
                gnt_a_c  = !prio_b_q;
                gnt_b_c  = prio_b_q;
                prio_b_d = !prio_b_q;
            end else begin
                gnt_a_c = req_a;
                gnt_b_c = req_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) prio_b_q <= 1'b0;
        else     prio_b_q <= prio_b_d;
    end

endmodule

// File: rtl/xgcd_operand_store.sv
// Banked operand memory shared by an SRAM-style bus port and a word-wide core port,
// with a built-in engine that zeroes every bank one word index per cycle.
module xgcd_operand_store
    import xgcd_store_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    localparam int unsigned BYTES  = DATA_W / 8,
    localparam int unsigned IDX_W  = calc_idx_w(DEPTH),
    localparam int unsigned BANK_W = calc_bank_w(NUM_BANKS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUS_CEn,
    input  logic              BUS_WEn,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    input  logic [DATA_W-1:0] BUS_WDATA,
    input  logic [BYTES-1:0]  BUS_WBEn,
    output logic              BUS_READY,
    output logic [DATA_W-1:0] BUS_RDATA,
    input  logic              CORE_REQ,
    input  logic              CORE_WE,
    input  logic [BANK_W-1:0] CORE_BANK,
    input  logic [IDX_W-1:0]  CORE_IDX,
    input  logic [DATA_W-1:0] CORE_WDATA,
    output logic              CORE_GNT,
    output logic              CORE_RVALID,
    output logic [DATA_W-1:0] CORE_RDATA,
    input  logic              CLR_START,
    output logic              CLR_BUSY,
    output logic              CLR_DONE
);

    localparam int unsigned BYTE_LSB = $clog2(BYTES);
    localparam int unsigned BANK_LSB = calc_bank_lsb(DATA_W, DEPTH);

    logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

    clr_state_e        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] bus_rdata_q, bus_rdata_d, core_rdata_q, core_rdata_d;
    logic              core_rvalid_q, core_rvalid_d;

    logic              bus_gnt_c, core_gnt_c, bus_hit_c, core_hit_c;
    logic [IDX_W-1:0]  bus_idx_c, wr_idx_c;
    logic [BANK_W-1:0] bus_bank_c, wr_bank_c;
    logic              wr_en_c, clr_we_c;
    logic [DATA_W-1:0] wr_data_c, wr_mask_c;

    // Nothing is granted while clearing or in reset, which also freezes the pointer.
    xgcd_store_arb u_arb (
        .clk     (CLK),
        .rst     (RESET),
        .freeze  (busy_q | RESET),
        .req_a   (!BUS_CEn),
        .req_b   (CORE_REQ),
        .gnt_a_c (bus_gnt_c),
        .gnt_b_c (core_gnt_c)
    );

    // Address decode and write-port selection for the single granted access.
    always_comb begin
        bus_idx_c  = BUS_ADDR[BYTE_LSB +: IDX_W];
        bus_bank_c = BUS_ADDR[BANK_LSB +: BANK_W];
        bus_hit_c  = addr_hit(64'(BUS_ADDR), BANK_LSB, NUM_BANKS);
        core_hit_c = bank_hit(32'(CORE_BANK), NUM_BANKS);

        wr_en_c   = 1'b0;
        wr_bank_c = CORE_BANK;
        wr_idx_c  = CORE_IDX;
        wr_data_c = CORE_WDATA;
        wr_mask_c = '1;
        if (bus_gnt_c) begin
            wr_en_c   = !BUS_WEn && bus_hit_c;
            wr_bank_c = bus_bank_c;
            wr_idx_c  = bus_idx_c;
            wr_data_c = BUS_WDATA;
            for (int unsigned y = 0; y < BYTES; y++) begin
                wr_mask_c[y*8 +: 8] = {8{!BUS_WBEn[y]}};
            end
        end else if (core_gnt_c) begin
            wr_en_c = CORE_WE && core_hit_c;
        end
        // Reset wins over an in-flight clear so the word under the counter survives.
        clr_we_c = (state_q == ST_CLEAR) && !RESET;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        always_ff @(posedge CLK) begin
            if (clr_we_c) begin
                mem_q[b][cnt_q] <= '0;
            end else if (wr_en_c && wr_bank_c == BANK_W'(b)) begin
                mem_q[b][wr_idx_c] <= (mem_q[b][wr_idx_c] & ~wr_mask_c) | (wr_data_c & wr_mask_c);
            end
        end
    end

    // Read-data capture and clear sequencing.
    always_comb begin
        bus_rdata_d   = bus_rdata_q;
        core_rdata_d  = core_rdata_q;
        core_rvalid_d = core_gnt_c && !CORE_WE;
        if (bus_gnt_c && BUS_WEn) begin
            bus_rdata_d = bus_hit_c ? mem_q[bus_bank_c][bus_idx_c] : '0;
        end
        if (core_gnt_c && !CORE_WE) begin
            core_rdata_d = core_hit_c ? mem_q[CORE_BANK][CORE_IDX] : '0;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (CLR_START) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_DONE;
                else                            cnt_d   = cnt_q + IDX_W'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bus_rdata_q   <= '0;
            core_rdata_q  <= '0;
            core_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            bus_rdata_q   <= bus_rdata_d;
            core_rdata_q  <= core_rdata_d;
            core_rvalid_q <= core_rvalid_d;
        end
    end

    assign BUS_READY   = bus_gnt_c;
    assign CORE_GNT    = core_gnt_c;
    assign BUS_RDATA   = bus_rdata_q;
    assign CORE_RDATA  = core_rdata_q;
    assign CORE_RVALID = core_rvalid_q;
    assign CLR_BUSY    = busy_q;
    assign CLR_DONE    = done_q;

endmodule

// File: tb/tb_xgcd_operand_store.sv
// Bench for xgcd_operand_store: cycle model of the default instance plus a 32/8/4 sweep instance.
module tb_xgcd_operand_store;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        bus_cen, bus_wen, bus_ready;
    logic [31:0] bus_addr;
    logic [63:0] bus_wdata, bus_rdata;
    logic [7:0]  bus_wben;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [0:0]  core_bank;
    logic [4:0]  core_idx;
    logic [63:0] core_wdata, core_rdata;
    logic        clr_start, clr_busy, clr_done;

    logic        s_cen, s_wen, s_ready, s_creq, s_cwe, s_cgnt, s_crvalid;
    logic [31:0] s_addr, s_wdata, s_rdata, s_cwdata, s_crdata;
    logic [3:0]  s_wben;
    logic [1:0]  s_cbank;
    logic [2:0]  s_cidx;
    logic        s_clr_start, s_clr_busy, s_clr_done;

    xgcd_operand_store dut (
        .CLK(clk), .RESET(rst),
        .BUS_CEn(bus_cen), .BUS_WEn(bus_wen), .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata),
        .BUS_WBEn(bus_wben), .BUS_READY(bus_ready), .BUS_RDATA(bus_rdata),
        .CORE_REQ(core_req), .CORE_WE(core_we), .CORE_BANK(core_bank), .CORE_IDX(core_idx),
        .CORE_WDATA(core_wdata), .CORE_GNT(core_gnt), .CORE_RVALID(core_rvalid),
        .CORE_RDATA(core_rdata), .CLR_START(clr_start), .CLR_BUSY(clr_busy), .CLR_DONE(clr_done)
    );

    xgcd_operand_store #(.DATA_W(32), .DEPTH(8), .NUM_BANKS(4), .ADDR_W(32)) dut_s (
        .CLK(clk), .RESET(rst),
        .BUS_CEn(s_cen), .BUS_WEn(s_wen), .BUS_ADDR(s_addr), .BUS_WDATA(s_wdata),
        .BUS_WBEn(s_wben), .BUS_READY(s_ready), .BUS_RDATA(s_rdata),
        .CORE_REQ(s_creq), .CORE_WE(s_cwe), .CORE_BANK(s_cbank), .CORE_IDX(s_cidx),
        .CORE_WDATA(s_cwdata), .CORE_GNT(s_cgnt), .CORE_RVALID(s_crvalid),
        .CORE_RDATA(s_crdata), .CLR_START(s_clr_start), .CLR_BUSY(s_clr_busy), .CLR_DONE(s_clr_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    // Behavioural model of the default instance: word array, last contention winner,
    // and a countdown of remaining busy cycles (32 clearing + 1 done).
    logic [63:0] m_mem [2][32];
    logic [63:0] m_brd = '0, m_crd = '0;
    bit          m_rv = 1'b0;
    int          busy_left = 0;
    int          clr_pos = 0;
    bit          last_core = 1'b1;
    bit          chk_en = 1'b0;

    function automatic void exp_grants(output bit gb, output bit gc);
        bit avail = !rst && busy_left == 0;
        bit rb = avail && !bus_cen;
        bit rc = avail && core_req;
        gb = rb && !(rc && !last_core);
        gc = rc && !(rb && last_core);
    endfunction

    always @(posedge clk) begin : model
        bit gb, gc;
        int unsigned word, bank, idx;
        exp_grants(gb, gc);
        if (rst) begin
            m_brd = '0; m_crd = '0; m_rv = 1'b0; busy_left = 0; last_core = 1'b1;
        end else begin
            if (!bus_cen && core_req && (gb || gc)) last_core = gc;
            m_rv = gc && !core_we;
            if (gb) begin
                word = bus_addr / 8;
                bank = word / 32;
                idx  = word % 32;
                if (bus_wen) m_brd = (bank < 2) ? m_mem[bank][idx] : 64'd0;
                else if (bank < 2)
                    for (int y = 0; y < 8; y++)
                        if (!bus_wben[y]) m_mem[bank][idx][y*8 +: 8] = bus_wdata[y*8 +: 8];
            end
            if (gc) begin
                if (core_we) m_mem[core_bank][core_idx] = core_wdata;
                else         m_crd = m_mem[core_bank][core_idx];
            end
            if (busy_left > 0) begin
                if (busy_left > 1) begin
                    for (int b = 0; b < 2; b++) m_mem[b][clr_pos] = '0;
                    clr_pos++;
                end
                busy_left--;
            end else if (clr_start) begin
                busy_left = 33;
                clr_pos   = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit gb, gc;
        if (chk_en) begin
            exp_grants(gb, gc);
            checkb("bus_ready", bus_ready, gb);
            checkb("core_gnt", core_gnt, gc);
            checkb("grant_exclusive", bus_ready & core_gnt, 1'b0);
            check("bus_rdata", bus_rdata, m_brd);
            check("core_rdata", core_rdata, m_crd);
            checkb("core_rvalid", core_rvalid, m_rv);
            checkb("clr_busy", clr_busy, busy_left > 0);
            checkb("clr_done", clr_done, busy_left == 1);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_op(input bit wen, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] wben, output logic [63:0] rd);
        int k = 0;
        bus_cen = 1'b0; bus_wen = wen; bus_addr = addr; bus_wdata = wd; bus_wben = wben;
        @(negedge clk);
        while (!bus_ready && k < 50) begin @(negedge clk); k++; end
        checkb("bus_grant_wait", bus_ready, 1'b1);
        tick();
        bus_cen = 1'b1;
        @(negedge clk);
        rd = bus_rdata;
        tick();
    endtask

    task automatic core_op(input bit we, input logic [0:0] bank, input logic [4:0] idx,
                           input logic [63:0] wd, output logic [63:0] rd);
        int k = 0;
        core_req = 1'b1; core_we = we; core_bank = bank; core_idx = idx; core_wdata = wd;
        @(negedge clk);
        while (!core_gnt && k < 50) begin @(negedge clk); k++; end
        checkb("core_grant_wait", core_gnt, 1'b1);
        tick();
        core_req = 1'b0;
        @(negedge clk);
        rd = core_rdata;
        tick();
    endtask

    task automatic s_bus_op(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        s_cen = 1'b0; s_wen = wen; s_addr = addr; s_wdata = wd; s_wben = 4'h0;
        @(negedge clk);
        checkb("sweep_bus_ready", s_ready, 1'b1);
        tick();
        s_cen = 1'b1;
        @(negedge clk);
        rd = s_rdata;
        tick();
    endtask

    task automatic s_core_rd(input logic [1:0] bank, input logic [2:0] idx, output logic [31:0] rd);
        s_creq = 1'b1; s_cwe = 1'b0; s_cbank = bank; s_cidx = idx;
        @(negedge clk);
        checkb("sweep_core_gnt", s_cgnt, 1'b1);
        tick();
        s_creq = 1'b0;
        @(negedge clk);
        checkb("sweep_core_rvalid", s_crvalid, 1'b1);
        rd = s_crdata;
        tick();
    endtask

    task automatic fill_ones();
        logic [63:0] rd;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++) core_op(1'b1, 1'(b), 5'(i), '1, rd);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [63:0] rd, nz;
        logic [31:0] srd, sexp;
        logic [7:0]  gseq;
        logic [4:0]  rvs;
        int busy_n, done_at, gnt_n;

        rst = 1'b1;
        bus_cen = 1'b1; bus_wen = 1'b1; bus_addr = '0; bus_wdata = '0; bus_wben = '1;
        core_req = 1'b0; core_we = 1'b0; core_bank = '0; core_idx = '0; core_wdata = '0;
        clr_start = 1'b0;
        s_cen = 1'b1; s_wen = 1'b1; s_addr = '0; s_wdata = '0; s_wben = '1;
        s_creq = 1'b0; s_cwe = 1'b0; s_cbank = '0; s_cidx = '0; s_cwdata = '0; s_clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        checkb("reset_busy", clr_busy, 1'b0);
        checkb("reset_rvalid", core_rvalid, 1'b0);
        check("reset_bus_rdata", bus_rdata, 64'd0);
        check("reset_core_rdata", core_rdata, 64'd0);
        tick();

        // Bring memory to a known state.
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        repeat (34) tick();

        // Byte-masked bus write.
        bus_op(1'b0, 32'h108, 64'h1122334455667788, 8'h00, rd);
        bus_op(1'b0, 32'h108, 64'hAAAAAAAABBBBBBBB, 8'hF0, rd);
        bus_op(1'b1, 32'h108, 64'd0, 8'hFF, rd);
        check("bytemask_read", rd, 64'h11223344BBBBBBBB);

        // Contention: both requesters for four cycles.
        gseq = '0; rvs = '0;
        bus_cen = 1'b0; bus_wen = 1'b1; bus_addr = 32'h108;
        core_req = 1'b1; core_we = 1'b0; core_bank = 1'b1; core_idx = 5'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gseq = {gseq[5:0], bus_ready, core_gnt};
            rvs  = {rvs[3:0], core_rvalid};
            tick();
        end
        bus_cen = 1'b1; core_req = 1'b0;
        @(negedge clk);
        rvs = {rvs[3:0], core_rvalid};
        check("arb_grant_sequence", 64'(gseq), 64'(8'b10_01_10_01));
        check("arb_rvalid_sequence", 64'(rvs), 64'(5'b00101));
        check("arb_core_rdata", core_rdata, 64'h11223344BBBBBBBB);
        tick();

        // Decode misses are accepted, write nothing and read zero.
        bus_op(1'b1, 32'h108, 64'd0, 8'hFF, rd);
        check("pre_miss_read", rd, 64'h11223344BBBBBBBB);
        bus_op(1'b0, 32'h208, 64'hDEADBEEFCAFEF00D, 8'h00, rd);
        bus_op(1'b1, 32'h208, 64'd0, 8'hFF, rd);
        check("miss_bank_read", rd, 64'd0);
        bus_op(1'b1, 32'h008, 64'd0, 8'hFF, rd);
        check("miss_no_alias_bank0", rd, 64'd0);
        bus_op(1'b1, 32'h108, 64'd0, 8'hFF, rd);
        bus_op(1'b1, 32'h8000_0108, 64'd0, 8'hFF, rd);
        check("miss_high_bits_read", rd, 64'd0);
        bus_op(1'b1, 32'h108, 64'd0, 8'hFF, rd);
        check("miss_no_alias_bank1", rd, 64'h11223344BBBBBBBB);

        // Core full-word write seen through the bus address map.
        core_op(1'b1, 1'b0, 5'd5, 64'h0123456789ABCDEF, rd);
        bus_op(1'b1, 32'h028, 64'd0, 8'hFF, rd);
        check("core_write_bus_read", rd, 64'h0123456789ABCDEF);

        // Clear with both requesters pending throughout.
        fill_ones();
        bus_cen = 1'b0; bus_wen = 1'b1; bus_addr = 32'h108;
        core_req = 1'b1; core_we = 1'b0; core_bank = 1'b0; core_idx = 5'd0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_n = 0; done_at = 0; gnt_n = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!clr_busy) break;
            busy_n++;
            if (clr_done) done_at = busy_n;
            if (bus_ready || core_gnt) gnt_n++;
            tick();
        end
        tick();
        bus_cen = 1'b1; core_req = 1'b0;
        check("clear_busy_cycles", 64'(busy_n), 64'd33);
        check("clear_done_cycle", 64'(done_at), 64'd33);
        check("clear_no_grants", 64'(gnt_n), 64'd0);
        nz = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++) begin
                bus_op(1'b1, 32'(b * 256 + i * 8), 64'd0, 8'hFF, rd);
                nz = nz | rd;
            end
        check("clear_all_zero", nz, 64'd0);

        // Reset while the clear counter sits at 10.
        fill_ones();
        bus_op(1'b1, 32'h1F8, 64'd0, 8'hFF, rd);
        core_op(1'b0, 1'b0, 5'd31, 64'd0, rd);
        check("midclr_pre_core_rdata", rd, 64'hFFFFFFFFFFFFFFFF);
        clr_start = 1'b1; tick(); clr_start = 1'b0;
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        checkb("midclr_busy", clr_busy, 1'b0);
        checkb("midclr_done", clr_done, 1'b0);
        check("midclr_bus_rdata", bus_rdata, 64'd0);
        check("midclr_core_rdata", core_rdata, 64'd0);
        tick();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++) begin
                core_op(1'b0, 1'(b), 5'(i), 64'd0, rd);
                check("midclr_word", rd, (i < 10) ? 64'd0 : 64'hFFFFFFFFFFFFFFFF);
            end

        // Sweep instance: 32-bit words, 8 deep, 4 banks; bank field is addr[6:5].
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i += 7)
                s_bus_op(1'b0, 32'(b * 32 + i * 4), 32'(32'hB000_0000 | (b << 8) | i), srd);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i += 7) begin
                sexp = 32'(32'hB000_0000 | (b << 8) | i);
                s_bus_op(1'b1, 32'(b * 32 + i * 4), 32'd0, srd);
                check("sweep_bus_read", 64'(srd), 64'(sexp));
                s_core_rd(2'(b), 3'(i), srd);
                check("sweep_core_read", 64'(srd), 64'(sexp));
            end
        s_bus_op(1'b1, 32'h0000_0080, 32'd0, srd);
        check("sweep_miss_read", 64'(srd), 64'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
